// File: rtl/pool_mc.sv
// rtl/pool_mc.sv - multi-channel 2x2 stride-2 max/average pooling over raster-scan feature maps
module pool_mc #(
    parameter int DATA_WIDTH   = 16,
    parameter int IMG_WIDTH    = 8,
    parameter int IMG_HEIGHT   = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic                         valid_in,
    input  logic                         mode,
    output logic signed [DATA_WIDTH-1:0] pool_dout,
    output logic                         pool_valid_out,
    output logic [CH_W-1:0]              pool_ch,
    output logic                         pool_last_ch,
    output logic                         pool_last,
    output logic                         busy
);

    localparam int OW = IMG_WIDTH / 2;
    localparam int OH = IMG_HEIGHT / 2;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int LW = (OW > 1) ? $clog2(OW) : 1;

    localparam logic [CW-1:0]   COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]   ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0]   COL_USE  = CW'(2 * OW - 1);
    localparam logic [RW-1:0]   ROW_USE  = RW'(2 * OH - 1);
    localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NUM_CHANNELS - 1);

    logic [CW-1:0]                 col;
    logic [RW-1:0]                 row;
    logic [CH_W-1:0]               ch;
    logic                          mode_q;
    logic signed [DATA_WIDTH-1:0]  pair;
    logic signed [DATA_WIDTH:0]    lb [OW];

    logic [LW-1:0]                 lb_idx;
    logic                          in_win;
    logic                          win_done;
    logic                          lb_wr;
    logic signed [DATA_WIDTH:0]    pair_ext;
    logic signed [DATA_WIDTH:0]    din_ext;
    logic signed [DATA_WIDTH:0]    h;
    logic signed [DATA_WIDTH:0]    stored;
    logic signed [DATA_WIDTH+1:0]  sum;
    logic signed [DATA_WIDTH+1:0]  avg;
    logic signed [DATA_WIDTH-1:0]  res;
    logic                          chan_end;
    logic                          layer_end;

    // Dropped odd trailing column/row pixels still advance the counters but never enter a window.
    always_comb begin
        lb_idx    = LW'(col >> 1);
        in_win    = (col <= COL_USE) && (row <= ROW_USE);
        win_done  = valid_in && in_win && col[0] && row[0];
        lb_wr     = valid_in && in_win && col[0] && !row[0];
        pair_ext  = {pair[DATA_WIDTH-1], pair};
        din_ext   = {din[DATA_WIDTH-1], din};
        if (mode_q)
            h = pair_ext + din_ext;
        else
            h = (pair_ext > din_ext) ? pair_ext : din_ext;
        stored    = lb[lb_idx];
        sum       = {stored[DATA_WIDTH], stored} + {h[DATA_WIDTH], h};
        avg       = sum >>> 2;
        if (mode_q)
            res = avg[DATA_WIDTH-1:0];
        else
            res = (stored > h) ? stored[DATA_WIDTH-1:0] : h[DATA_WIDTH-1:0];
        chan_end  = (col == COL_LAST) && (row == ROW_LAST);
        layer_end = chan_end && (ch == CH_LAST);
    end

    always_ff @(posedge clk) begin
        if (lb_wr)
            lb[lb_idx] <= h;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col            <= '0;
            row            <= '0;
            ch             <= '0;
            mode_q         <= 1'b0;
            pair           <= '0;
            pool_dout      <= '0;
            pool_valid_out <= 1'b0;
            pool_ch        <= '0;
            pool_last_ch   <= 1'b0;
            pool_last      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            pool_valid_out <= 1'b0;
            pool_last_ch   <= 1'b0;
            pool_last      <= 1'b0;
            if (valid_in) begin
                if (col == '0 && row == '0)
                    mode_q <= mode;
                if (!col[0])
                    pair <= din;
                if (win_done) begin
                    pool_dout      <= res;
                    pool_valid_out <= 1'b1;
                    pool_ch        <= ch;
                    pool_last_ch   <= (col == COL_USE) && (row == ROW_USE);
                    pool_last      <= (col == COL_USE) && (row == ROW_USE) && (ch == CH_LAST);
                end
                busy <= !layer_end;
                if (col == COL_LAST) begin
                    col <= '0;
                    if (row == ROW_LAST) begin
                        row <= '0;
                        ch  <= (ch == CH_LAST) ? '0 : ch + 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_mc.sv
// tb/tb_pool_mc.sv - bench for pool_mc: 8x8x4 and 5x5x2 instances against a frame-level window model
module tb_pool_mc;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] din;
    logic               mode;
    logic               va, vb;

    logic signed [15:0] dout_a, dout_b;
    logic               vo_a, vo_b;
    logic [1:0]         ch_a;
    logic [0:0]         ch_b;
    logic               lc_a, lc_b, l_a, l_b, busy_a, busy_b;

    int n_cmp = 0;
    int n_bad = 0;

    int frame [2][4][8][8];
    bit cmode [2][4];
    int mcol [2];
    int mrow [2];
    int mch  [2];

    always #5 clk = ~clk;

    pool_mc #(.DATA_WIDTH(16), .IMG_WIDTH(8), .IMG_HEIGHT(8), .NUM_CHANNELS(4)) u_a (
        .clk(clk), .reset(reset), .din(din), .valid_in(va), .mode(mode),
        .pool_dout(dout_a), .pool_valid_out(vo_a), .pool_ch(ch_a),
        .pool_last_ch(lc_a), .pool_last(l_a), .busy(busy_a)
    );

    pool_mc #(.DATA_WIDTH(16), .IMG_WIDTH(5), .IMG_HEIGHT(5), .NUM_CHANNELS(2)) u_b (
        .clk(clk), .reset(reset), .din(din), .valid_in(vb), .mode(mode),
        .pool_dout(dout_b), .pool_valid_out(vo_b), .pool_ch(ch_b),
        .pool_last_ch(lc_b), .pool_last(l_b), .busy(busy_b)
    );

    task automatic px(input int sel, input int v, input bit m);
        int  w, hgt, nc, ow, oh, r, c, p0, p1, p2, p3, e;
        bit  strobe, lc, ll, obs_v, exp_busy;
        logic [19:0] obs, expv;
        w   = sel ? 5 : 8;
        hgt = sel ? 5 : 8;
        nc  = sel ? 2 : 4;
        ow  = w / 2;
        oh  = hgt / 2;
        din  = 16'(v);
        mode = m;
        va   = (sel == 0);
        vb   = (sel == 1);
        @(posedge clk);
        #1;
        va = 1'b0;
        vb = 1'b0;
        frame[sel][mch[sel]][mrow[sel]][mcol[sel]] = v;
        if (mrow[sel] == 0 && mcol[sel] == 0)
            cmode[sel][mch[sel]] = m;
        strobe = (mrow[sel] % 2 == 1) && (mcol[sel] % 2 == 1) && (mrow[sel] < 2 * oh) && (mcol[sel] < 2 * ow);
        obs_v  = sel ? vo_b : vo_a;
        n_cmp++;
        assert (obs_v === strobe) else begin
            n_bad++;
            $error("FAIL strobe dut%0d ch%0d r%0d c%0d: observed %0b expected %0b", sel, mch[sel], mrow[sel], mcol[sel], obs_v, strobe);
        end
        if (strobe && obs_v) begin
            r  = mrow[sel] / 2;
            c  = mcol[sel] / 2;
            p0 = frame[sel][mch[sel]][2*r][2*c];
            p1 = frame[sel][mch[sel]][2*r][2*c+1];
            p2 = frame[sel][mch[sel]][2*r+1][2*c];
            p3 = frame[sel][mch[sel]][2*r+1][2*c+1];
            if (cmode[sel][mch[sel]]) begin
                e = (p0 + p1 + p2 + p3) >>> 2;
            end else begin
                e = p0;
                if (p1 > e) e = p1;
                if (p2 > e) e = p2;
                if (p3 > e) e = p3;
            end
            lc   = (r == oh - 1) && (c == ow - 1);
            ll   = lc && (mch[sel] == nc - 1);
            expv = {16'(e), 2'(mch[sel]), lc, ll};
            obs  = sel ? {dout_b, 1'b0, ch_b, lc_b, l_b} : {dout_a, ch_a, lc_a, l_a};
            n_cmp++;
            assert (obs === expv) else begin
                n_bad++;
                $error("FAIL out dut%0d ch%0d win(%0d,%0d): observed %h expected %h", sel, mch[sel], r, c, obs, expv);
            end
        end
        if (sel == 0) begin
            exp_busy = !(mcol[0] == 7 && mrow[0] == 7 && mch[0] == 3);
            n_cmp++;
            assert (busy_a === exp_busy) else begin
                n_bad++;
                $error("FAIL busy ch%0d r%0d c%0d: observed %0b expected %0b", mch[0], mrow[0], mcol[0], busy_a, exp_busy);
            end
        end
        if (mcol[sel] == w - 1) begin
            mcol[sel] = 0;
            if (mrow[sel] == hgt - 1) begin
                mrow[sel] = 0;
                mch[sel]  = (mch[sel] == nc - 1) ? 0 : mch[sel] + 1;
            end else begin
                mrow[sel]++;
            end
        end else begin
            mcol[sel]++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            din  = 16'($urandom);
            mode = 1'($urandom);
            @(posedge clk);
            #1;
            n_cmp++;
            assert ({vo_a, vo_b} === 2'b00) else begin
                n_bad++;
                $error("FAIL gap_strobe: observed %b expected 00", {vo_a, vo_b});
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        n_cmp++;
        assert ({dout_a, vo_a, ch_a, lc_a, l_a, busy_a, dout_b, vo_b, ch_b, lc_b, l_b, busy_b} === '0) else begin
            n_bad++;
            $error("FAIL reset_state: observed a=%h/%b/%h/%b/%b/%b b=%h/%b/%h/%b/%b/%b expected all zero",
                   dout_a, vo_a, ch_a, lc_a, l_a, busy_a, dout_b, vo_b, ch_b, lc_b, l_b, busy_b);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            mcol[s] = 0;
            mrow[s] = 0;
            mch[s]  = 0;
        end
    endtask

    task automatic layer_a(input int kind);
        logic signed [15:0] t;
        int v;
        bit m;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 64; i++) begin
                t = 16'($urandom);
                case (kind)
                    0: begin v = i; m = 1'b0; end
                    1: begin v = i; m = 1'b1; end
                    2: begin
                        v = (c == 0) ? ((i % 2 == 1) ? -2 : -1) : int'(t);
                        m = (c == 0) ? 1'b1 : (c == 1) ? 1'b0 : 1'(c == 3);
                    end
                    default: begin
                        v = i + 10 * c;
                        m = 1'($urandom);
                        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                    end
                endcase
                px(0, v, m);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        din   = '0;
        mode  = 1'b0;
        va    = 1'b0;
        vb    = 1'b0;
        #1;
        do_reset();
        idle(2);

        layer_a(0);
        layer_a(1);
        layer_a(2);
        idle(3);
        layer_a(3);

        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 25; i++)
                px(1, i, 1'b0);
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 25; i++) begin
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
                px(1, $signed(16'($urandom)), (c == 0));
            end

        for (int i = 0; i < 30; i++)
            px(0, i, 1'b0);
        do_reset();
        idle(2);
        layer_a(0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pool_mc.md
# pool_mc

Parametrised multi-channel 2x2/stride-2 pooling unit, the successor to the single-mode `pool` block, sitting between the convolution/activation stage and the dense layer of the CNN datapath. It accepts channel-major raster-scan feature maps, one pixel per `valid_in` beat with arbitrary gaps. It emits one pooled value per 2x2 window in max or average mode, tagged with channel index and end-of-channel and end-of-layer flags. Arbitrary image dimensions are supported, including odd ones.

## Interface
- DATA_WIDTH, 16: signed pixel width (Q8.8 in the current datapath).
- IMG_WIDTH, 8: input columns per channel, ≥2.
- IMG_HEIGHT, 8: input rows per channel, ≥2.
- NUM_CHANNELS, 4: feature maps per layer, ≥1.
- CH_W, $clog2(NUM_CHANNELS) (minimum 1): width of `pool_ch`.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (the port keeps the codebase name `reset`; asserted while 0).
- din  in  DATA_WIDTH  signed input pixel; ignored when `valid_in`=0.
- valid_in  in  1  pixel accepted on a rising edge with `valid_in`=1.
- mode  in  1  0 selects max, 1 selects average; sampled only with the first pixel of each channel.
- pool_dout  out  DATA_WIDTH  signed pooled value.
- pool_valid_out  out  1  one-cycle strobe per pooled value.
- pool_ch  out  CH_W  channel index of the current `pool_dout`.
- pool_last_ch  out  1  high with the final output of each channel.
- pool_last  out  1  high with the final output of channel NUM_CHANNELS-1.
- busy  out  1  high from the first accepted pixel of a layer until `pool_last`.

## Operation
- Counters: `col` (0..IMG_WIDTH-1), `row` (0..IMG_HEIGHT-1) and `ch` (0..NUM_CHANNELS-1) advance only on accepted pixels. Raster order with column fastest, then row, then channel.
- Effective output size: OW = IMG_WIDTH/2 and OH = IMG_HEIGHT/2, both floor.
  - When IMG_WIDTH is odd, pixels in column IMG_WIDTH-1 are counted and dropped.
  - When IMG_HEIGHT is odd, all pixels in row IMG_HEIGHT-1 are counted and dropped.
- Horizontal stage:
  - On even `col`, the pixel is held in a pair register.
  - On odd `col`, the pair combines into h = max(a,b) or h = a+b, using DATA_WIDTH+1 signed bits.
- Line buffer: OW entries of DATA_WIDTH+1 bits. On even `row`, h is written at index `col`/2. On odd `row`, h combines with the stored entry.
- Result:
  - Max mode: max of the two, truncated to DATA_WIDTH. The value always fits.
  - Average mode: a DATA_WIDTH+2 signed sum, arithmetically shifted right by 2, which floors toward −∞.
- Mode latch: `mode` is captured when a pixel with `col`=0, `row`=0 is accepted. It holds for the rest of that channel; mid-channel changes have no effect.
- Flags:
  - `pool_last_ch` is asserted on the output at window (OH-1, OW-1).
  - `pool_last` is asserted when `pool_last_ch` is asserted and `ch`=NUM_CHANNELS-1.
- Wrap: after the final pixel of a channel, `col`/`row` return to 0 and `ch` increments. After the final channel, `ch` returns to 0 and `busy` falls. The next pixel starts a new layer with no idle cycles required.

## Timing
- Reset (`reset`=0, asynchronous): `pool_dout`=0, `pool_valid_out`=0, `pool_ch`=0, `pool_last_ch`=0, `pool_last`=0, `busy`=0, and all counters and the mode latch are 0. Line-buffer contents are don't-care.
- Latency:
  - The pixel at (odd row, odd col) accepted on edge k produces `pool_valid_out`=1 in the cycle following edge k.
  - It is registered at edge k and falls at edge k+1 unless another window completes.
  - `pool_dout`, `pool_ch` and the flags are valid only while `pool_valid_out`=1. `pool_dout` holds its last value otherwise.
- Throughput: one pixel per cycle sustained, with no backpressure. Back-to-back channels and layers are accepted at full rate.
- Gaps: `valid_in`=0 for any number of cycles freezes all state.
- Reset mid-frame: the partial frame is discarded. The first pixel after deassertion is pixel (0,0) of channel 0.
- Channel switch: the line buffer is fully overwritten by the even rows of the next channel, so no clearing is needed.

## Test plan
- 8x8, 1 channel, max mode, din=idx (0..63), continuous: 16 outputs, in order 9, 11, 13, 15, 25, 27, … 63. `pool_last_ch` and `pool_last` are asserted on 63 only.
- Same stimulus in average mode: the first output is (0+1+8+9)>>2 = 4 and the last is (54+55+62+63)>>2 = 58.
- Negative average with window pixels −1, −2, −1, −2: output is −2, not −1. Max of −5, −3, −7, −4: output is −3.
- 5x5, 2 channels, max, din=idx: 4 outputs per channel, namely 6, 8, 16, 18. Column 4 and row 4 are dropped. `pool_ch` goes 0 then 1, and `pool_last` is asserted on the 8th output.
- 8x8, 4 channels, din=idx+10·ch, random `valid_in` gaps, and `mode` toggled mid-channel: 64 outputs match the reference model. The mode follows each channel's first pixel, and `pool_last` is asserted on output 64.
- Assert `reset`=0 after 30 pixels, then resend a full 8x8 frame: no stale output appears, and the output sequence matches the first scenario.
